// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall sequencer:
//   - state_e   : sequencer states (RUN, LU_HOLD, MEM_WAIT)
//   - ctrl_t    : bundle of the five pipeline control outputs
//   - CTRL_*    : canned control patterns (idle, freeze, bubble, flush)
//   - REG_W     : register-number width
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;   // 1 = IF/ID holds its contents
        logic ifid_flush;
        logic stall;
        logic bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      stall: 1'b0, bubble: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      stall: 1'b1, bubble: 1'b0};
    localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      stall: 1'b0, bubble: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1,
                                      stall: 1'b0, bubble: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the hazard sequencer and the pipeline datapath.
//   hazard status : mem_stall_i, branch_taken_i, idex_memread_i, idex_rt_i,
//                   ifid_rs_i, ifid_rt_i
//   controls      : pc_write_o, ifid_write_o, ifid_flush_o, stall_o, bubble_o
//   monitoring    : stall_cnt_o, flush_cnt_o (CNT_W bits), wdt_o
// modport master : the sequencer (consumes status, drives controls)
// modport slave  : the pipeline side (drives status, consumes controls)
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             mem_stall_i;
    logic             branch_taken_i;
    logic             idex_memread_i;
    logic [REG_W-1:0] idex_rt_i;
    logic [REG_W-1:0] ifid_rs_i;
    logic [REG_W-1:0] ifid_rt_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             stall_o;
    logic             bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             wdt_o;

    modport master (
        input  mem_stall_i, branch_taken_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, stall_o, bubble_o,
        output stall_cnt_o, flush_cnt_o, wdt_o
    );

    modport slave (
        output mem_stall_i, branch_taken_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, stall_o, bubble_o,
        input  stall_cnt_o, flush_cnt_o, wdt_o
    );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit event counter that sticks at all-ones instead of wrapping.
//   clk_i   : clock
//   clear   : synchronous clear (takes priority over inc)
//   inc     : count this cycle
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count_o
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and stall sequencer for the 5-stage pipeline. Arbitrates cache-miss
// freezes, taken-branch flushes and load-use bubbles (priority in that order),
// and keeps saturating stall/flush counters plus a sticky miss watchdog.
//   clk_i : clock, rst_i : synchronous active-high reset
//   bus   : pipeline_hazard_ctrl_if.master (status in, controls/counters out)
// Control outputs are combinational from state and inputs, so they settle
// inside the cycle for the negedge-clocked IF/ID register.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int WDT_LIMIT  = 1023,
    parameter int CNT_W      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pipeline_hazard_ctrl_if.master  bus
);
    localparam int               WDT_W     = $clog2(WDT_LIMIT + 1);
    localparam logic [WDT_W-1:0] WDT_LIM_V = WDT_W'(WDT_LIMIT);
    localparam logic [2:0]       LU_INIT   = 3'(LU_BUBBLES - 1);

    state_e           r_state;
    state_e           r_ret_state;
    logic [2:0]       r_lu_cnt;
    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt;

    state_e           w_state_next;
    state_e           w_ret_next;
    state_e           w_eff_state;
    logic [2:0]       w_lu_cnt_next;
    logic [WDT_W-1:0] w_wdt_cnt_next;
    logic             w_lu_haz;
    ctrl_t            w_ctrl;

    assign w_lu_haz = bus.idex_memread_i && (bus.idex_rt_i != '0) &&
                      ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

    // Once a miss clears, MEM_WAIT behaves exactly like the state it interrupted.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

    always_comb begin
        w_ctrl        = CTRL_IDLE;
        w_state_next  = r_state;
        w_ret_next    = r_ret_state;
        w_lu_cnt_next = r_lu_cnt;

        if (rst_i) begin
            w_state_next = RUN;
        end else if (bus.mem_stall_i) begin
            // Freeze everything; lu_cnt holds so the remaining bubbles resume later.
            w_ctrl       = CTRL_FREEZE;
            w_state_next = MEM_WAIT;
            w_ret_next   = (r_state == MEM_WAIT) ? r_ret_state : r_state;
        end else begin
            case (w_eff_state)
                LU_HOLD: begin
                    // ID is frozen here, so a branch seen now is not yet real.
                    w_ctrl        = CTRL_BUBBLE;
                    w_lu_cnt_next = r_lu_cnt - 3'd1;
                    w_state_next  = (r_lu_cnt <= 3'd1) ? RUN : LU_HOLD;
                end
                default: begin
                    w_state_next = RUN;
                    if (bus.branch_taken_i) begin
                        w_ctrl = CTRL_FLUSH;
                    end else if (w_lu_haz) begin
                        w_ctrl = CTRL_BUBBLE;
                        if (LU_BUBBLES > 1) begin
                            w_lu_cnt_next = LU_INIT;
                            w_state_next  = LU_HOLD;
                        end
                    end
                end
            endcase
        end
    end

    // Counts MEM_WAIT cycles including the one being entered, so the flag is
    // visible during the WDT_LIMIT-th consecutive MEM_WAIT cycle.
    always_comb begin
        w_wdt_cnt_next = '0;
        if (!rst_i && bus.mem_stall_i) begin
            w_wdt_cnt_next = (r_wdt_cnt == WDT_LIM_V) ? r_wdt_cnt : r_wdt_cnt + WDT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_lu_cnt    <= '0;
            r_wdt_cnt   <= '0;
            r_wdt       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ret_state <= w_ret_next;
            r_lu_cnt    <= w_lu_cnt_next;
            r_wdt_cnt   <= w_wdt_cnt_next;
            r_wdt       <= r_wdt | (w_wdt_cnt_next == WDT_LIM_V);
        end
    end

    // Counter 0: stall/bubble cycles, counter 1: flushes issued.
    logic [1:0]       w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_q [2];

    assign w_cnt_inc[0] = w_ctrl.stall | w_ctrl.bubble;
    assign w_cnt_inc[1] = w_ctrl.ifid_flush;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i   (clk_i),
            .clear   (rst_i),
            .inc     (w_cnt_inc[gi]),
            .count_o (w_cnt_q[gi])
        );
    end

    assign bus.pc_write_o   = w_ctrl.pc_write;
    assign bus.ifid_write_o = w_ctrl.ifid_write;
    assign bus.ifid_flush_o = w_ctrl.ifid_flush;
    assign bus.stall_o      = w_ctrl.stall;
    assign bus.bubble_o     = w_ctrl.bubble;
    assign bus.stall_cnt_o  = w_cnt_q[0];
    assign bus.flush_cnt_o  = w_cnt_q[1];
    assign bus.wdt_o        = r_wdt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two sequencer instances (3 bubbles / watchdog 8 / 4-bit counters, and
// 1 bubble / watchdog 20 / 8-bit counters) share one stimulus stream: a short
// directed prologue followed by random traffic. Each instance is compared
// every cycle against a model that only tracks "bubbles still owed", the
// current run of miss cycles and event totals.
// Control vector order: {pc_write, ifid_write, ifid_flush, stall, bubble}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) bus0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(8)) bus1 ();

    pipeline_hazard_ctrl #(.LU_BUBBLES(3), .WDT_LIMIT(8), .CNT_W(4)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    pipeline_hazard_ctrl #(.LU_BUBBLES(1), .WDT_LIMIT(20), .CNT_W(8)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    int lub  [2] = '{3, 1};
    int wlim [2] = '{8, 20};
    int cmax [2] = '{15, 255};

    int bub_left [2];
    int streak   [2];
    int scnt     [2];
    int fcnt     [2];
    bit wdt_m    [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, n_cyc, got, exp);
        end
    endtask

    // Expected controls for this cycle, then advance the model past the posedge.
    task automatic model_cycle(input int d, input bit r, input bit ms, input bit br,
                               input bit lh, output logic [4:0] ectrl);
        ectrl = 5'b10000;
        if (r) begin
            bub_left[d] = 0;
            streak[d]   = 0;
            scnt[d]     = 0;
            fcnt[d]     = 0;
            wdt_m[d]    = 1'b0;
            return;
        end
        if (ms) begin
            ectrl = 5'b01010;
        end else if (bub_left[d] > 0) begin
            ectrl = 5'b01001;
            bub_left[d]--;
        end else if (br) begin
            ectrl = 5'b10100;
        end else if (lh) begin
            ectrl = 5'b01001;
            bub_left[d] = lub[d] - 1;
        end
        // After N back-to-back miss cycles the sequencer sits in its N-th MEM_WAIT cycle.
        streak[d] = ms ? streak[d] + 1 : 0;
        if (streak[d] >= wlim[d]) wdt_m[d] = 1'b1;
        if ((ectrl[1] || ectrl[0]) && scnt[d] < cmax[d]) scnt[d]++;
        if (ectrl[2] && fcnt[d] < cmax[d]) fcnt[d]++;
    endtask

    task automatic apply(input bit r, input bit ms, input bit br, input bit mr,
                         input logic [4:0] irt, input logic [4:0] rs, input logic [4:0] rt);
        logic [4:0] ectrl;
        logic [4:0] got0;
        logic [4:0] got1;
        bit lh;
        @(negedge clk);
        rst = r;
        bus0.mem_stall_i = ms; bus0.branch_taken_i = br; bus0.idex_memread_i = mr;
        bus0.idex_rt_i = irt;  bus0.ifid_rs_i = rs;       bus0.ifid_rt_i = rt;
        bus1.mem_stall_i = ms; bus1.branch_taken_i = br; bus1.idex_memread_i = mr;
        bus1.idex_rt_i = irt;  bus1.ifid_rs_i = rs;       bus1.ifid_rt_i = rt;
        #1;
        lh   = mr && (irt != 5'd0) && ((irt == rs) || (irt == rt));
        got0 = {bus0.pc_write_o, bus0.ifid_write_o, bus0.ifid_flush_o, bus0.stall_o, bus0.bubble_o};
        got1 = {bus1.pc_write_o, bus1.ifid_write_o, bus1.ifid_flush_o, bus1.stall_o, bus1.bubble_o};

        check_val("d0 stall_cnt", 32'(bus0.stall_cnt_o), scnt[0]);
        check_val("d0 flush_cnt", 32'(bus0.flush_cnt_o), fcnt[0]);
        check_val("d0 wdt",       32'(bus0.wdt_o),       32'(wdt_m[0]));
        model_cycle(0, r, ms, br, lh, ectrl);
        check_val("d0 ctrl",      32'(got0),             32'(ectrl));

        check_val("d1 stall_cnt", 32'(bus1.stall_cnt_o), scnt[1]);
        check_val("d1 flush_cnt", 32'(bus1.flush_cnt_o), fcnt[1]);
        check_val("d1 wdt",       32'(bus1.wdt_o),       32'(wdt_m[1]));
        model_cycle(1, r, ms, br, lh, ectrl);
        check_val("d1 ctrl",      32'(got1),             32'(ectrl));

        $display("cyc %0d rst=%0b ms=%0b br=%0b lh=%0b ctrl0=%05b ctrl1=%05b cnt0=%0d/%0d wdt0=%0b",
                 n_cyc, r, ms, br, lh, got0, got1, bus0.stall_cnt_o, bus0.flush_cnt_o, bus0.wdt_o);
        n_cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        int burst;
        bit r;
        bit ms;
        for (int d = 0; d < 2; d++) begin
            bub_left[d] = 0; streak[d] = 0; scnt[d] = 0; fcnt[d] = 0; wdt_m[d] = 1'b0;
        end
        bus0.mem_stall_i = 1'b0; bus0.branch_taken_i = 1'b0; bus0.idex_memread_i = 1'b0;
        bus0.idex_rt_i = '0; bus0.ifid_rs_i = '0; bus0.ifid_rt_i = '0;
        bus1.mem_stall_i = 1'b0; bus1.branch_taken_i = 1'b0; bus1.idex_memread_i = 1'b0;
        bus1.idex_rt_i = '0; bus1.ifid_rs_i = '0; bus1.ifid_rt_i = '0;
        repeat (2) @(posedge clk);

        // Reset state, then a single load-use hazard on r5.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        idle(4);
        // Branch pulse, then branch together with a load-use hazard.
        apply(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(1);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7);
        idle(2);
        // Miss arriving in the middle of the bubble sequence.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        idle(1);
        for (int k = 0; k < 4; k++) apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(3);
        // Long miss: watchdog trips and stays set; 4-bit counter saturates.
        for (int k = 0; k < 10; k++) apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(3);
        // Reset in the middle of a miss, then a match on r0 (no hazard).
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(2);

        // Random traffic with miss bursts and occasional resets.
        burst = 0;
        for (int k = 0; k < 1500; k++) begin
            r = ($urandom_range(0, 149) == 0);
            if (burst > 0) begin
                ms = 1'b1;
                burst--;
            end else if ($urandom_range(0, 9) == 0) begin
                ms = 1'b1;
                burst = $urandom_range(0, 24);
            end else begin
                ms = 1'b0;
            end
            apply(r, ms, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall sequencer for the 5-stage pipeline. It generates the hold, flush, global-stall and bubble controls consumed by the IF/ID register, the PC and the ID/EX control mux. It arbitrates three sources:

- data-cache miss stalls;
- taken-branch flushes resolved in ID;
- load-use hazards, which need a configurable number of bubbles.

It also keeps saturating stall and flush counters and a miss watchdog.

## Interface
Parameters:
- LU_BUBBLES, default 1: bubbles inserted per load-use hazard (1..7).
- WDT_LIMIT, default 1023: maximum consecutive MEM_WAIT cycles before the watchdog fires.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk_i  in  1  single clock; all state updates on the posedge.
- rst_i  in  1  reset, synchronous and active-high.
- mem_stall_i  in  1  data cache busy (miss outstanding); level, held until data is ready.
- branch_taken_i  in  1  taken branch/jump resolved in ID this cycle.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rt_i  in  5  destination register of the EX load.
- ifid_rs_i  in  5  rs of the instruction in ID.
- ifid_rt_i  in  5  rt of the instruction in ID.
- pc_write_o  out  1  1 = PC may advance.
- ifid_write_o  out  1  1 = IF/ID holds its contents (IF/ID convention).
- ifid_flush_o  out  1  1 = IF/ID loads a NOP.
- stall_o  out  1  global freeze of all pipeline registers.
- bubble_o  out  1  1 = zero the ID/EX control signals.
- stall_cnt_o  out  CNT_W  cycles with stall_o or bubble_o high; saturating.
- flush_cnt_o  out  CNT_W  count of flushes issued; saturating.
- wdt_o  out  1  sticky watchdog flag.

## Operation
States:
- RUN: normal flow.
- LU_HOLD: load-use bubbles in progress; 3-bit counter `lu_cnt`.
- MEM_WAIT: cache miss; `ret_state` records RUN or LU_HOLD.

Load-use hazard (`lu_haz`) = idex_memread_i & idex_rt_i≠0 & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).

Outputs are Mealy, computed from the current state and inputs. Priority is mem_stall_i > branch_taken_i > lu_haz.

- **mem_stall_i=1 (any state):**
  - Outputs: stall_o=1, pc_write_o=0, ifid_write_o=1, flush 0, bubble 0.
  - Next state MEM_WAIT; `ret_state` is the current state, except that MEM_WAIT keeps its stored `ret_state`.
  - `lu_cnt` is frozen.
- **MEM_WAIT with mem_stall_i=0:** outputs are evaluated as in `ret_state` in the same cycle; the next state follows the rules for that state.
- **RUN with branch_taken_i=1:** ifid_flush_o=1, pc_write_o=1, flush_cnt_o+1. Any simultaneous lu_haz is ignored.
- **RUN with lu_haz:**
  - Outputs: pc_write_o=0, ifid_write_o=1, bubble_o=1.
  - If LU_BUBBLES>1: `lu_cnt`←LU_BUBBLES−1 and next state LU_HOLD. Otherwise stay in RUN.
- **LU_HOLD:**
  - Outputs are the same as the lu_haz case; `lu_cnt` decrements each cycle.
  - At `lu_cnt`==1, next state is RUN.
  - branch_taken_i is ignored, because ID is frozen.
- **Idle outputs:** pc_write_o=1, ifid_write_o=0, ifid_flush_o=0, stall_o=0, bubble_o=0.

Counters:
- stall_cnt_o increments in any cycle with stall_o|bubble_o.
- Both counters saturate at all-ones and never wrap.

Watchdog:
- A `wdt_cnt` counts consecutive MEM_WAIT cycles and clears on leaving MEM_WAIT.
- When `wdt_cnt` reaches WDT_LIMIT, wdt_o is set and stays set until reset.
- Pipeline behaviour is unchanged when the watchdog fires.

## Timing
- Reset (rst_i=1 at a posedge):
  - state RUN, `lu_cnt`=0, `ret_state`=RUN, all counters 0, wdt_o=0.
  - While rst_i is high, outputs are forced to idle values.
- Reset mid-miss or mid-bubble abandons the sequence with no pending flush.
- Control latency is 0: outputs settle within the cycle so that the negedge-clocked IF/ID samples them.
- Counter and state updates appear the cycle after the posedge.
- A load-use hazard costs exactly LU_BUBBLES cycles of bubble_o, excluding any cycles frozen in MEM_WAIT.

## Structure
- A shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN=2'd0, LU_HOLD=2'd1, MEM_WAIT=2'd2);
  - the idle output constant;
  - the register-number width (5).
- One sub-module, `sat_counter` (parameter W, inc, clear), is instantiated for stall_cnt and flush_cnt.
- The hazard compare and output decode stay inline.

## Test plan
- **Load-use:** LU_BUBBLES=2, idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for 1 cycle → bubble_o=1 and pc_write_o=0 for exactly 2 cycles, then idle; stall_cnt_o=2.
- **Branch:** branch_taken_i pulse in RUN → ifid_flush_o=1 for 1 cycle, pc_write_o=1, flush_cnt_o=1.
- **Branch with lu_haz:** simultaneous branch_taken_i and lu_haz → flush only, bubble_o=0.
- **Miss during bubbles:** mem_stall_i high 4 cycles starting in the 2nd LU_HOLD cycle (LU_BUBBLES=3) → stall_o=1 ×4 with `lu_cnt` frozen, then 1 remaining bubble cycle, then RUN; stall_cnt_o=7.
- **Watchdog and saturation:** WDT_LIMIT=8, mem_stall_i held 10 cycles → wdt_o rises on the 8th MEM_WAIT cycle and stays set after mem_stall_i drops. Counters preloaded near all-ones, with CNT_W=4 → stall_cnt_o saturates at 15.
- **Mid-stall reset:** rst_i asserted during MEM_WAIT → next cycle is RUN, outputs idle, counters 0, wdt_o=0; idex_rt_i=0 with a match → no bubble.
